// File: rtl/i2c_sensor_target.sv
// I2C target emulating one sensor: acks its 7-bit address, returns a captured
// 16-bit word MSB-first on reads, and accepts up to two data bytes on writes.
module i2c_sensor_target #(
  parameter logic [6:0] ADDR = 7'b1001000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] data_in,
  output logic        rd_latch,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StTx, StMack, StRx, StRxAck, StWaitStop
  } state_e;

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  state_e      r_state, w_state_d;
  logic [3:0]  r_bit_cnt, w_bit_cnt_d;
  logic [7:0]  r_shift, w_shift_d;
  logic        r_rw, w_rw_d;
  logic [15:0] r_tx_word, w_tx_word_d;
  logic        r_byte_idx, w_byte_idx_d;
  logic [1:0]  r_rx_cnt, w_rx_cnt_d;
  logic [7:0]  r_byte0, w_byte0_d;
  logic        r_sda_oe, w_sda_oe_d;
  logic        r_rd_latch, w_rd_latch_d;
  logic [15:0] r_wr_data, w_wr_data_d;
  logic        r_wr_valid, w_wr_valid_d;
  logic        r_busy, w_busy_d;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_match;
  logic [7:0] w_tx_byte;

  // Conditions need SCL high on both the current and previous sample
  assign w_scl_rise = r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_sync & r_scl_prev;
  assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
  assign w_match    = (r_shift[7:1] == ADDR) && (r_shift[7:1] != 7'd0);
  assign w_tx_byte  = r_byte_idx ? r_tx_word[7:0] : r_tx_word[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state    <= StIdle;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_rw       <= 1'b0;
      r_tx_word  <= 16'd0;
      r_byte_idx <= 1'b0;
      r_rx_cnt   <= 2'd0;
      r_byte0    <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_rd_latch <= 1'b0;
      r_wr_data  <= 16'd0;
      r_wr_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_meta <= scl_in;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= sda_in;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_state    <= w_state_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_rw       <= w_rw_d;
      r_tx_word  <= w_tx_word_d;
      r_byte_idx <= w_byte_idx_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_byte0    <= w_byte0_d;
      r_sda_oe   <= w_sda_oe_d;
      r_rd_latch <= w_rd_latch_d;
      r_wr_data  <= w_wr_data_d;
      r_wr_valid <= w_wr_valid_d;
      r_busy     <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_bit_cnt_d  = r_bit_cnt;
    w_shift_d    = r_shift;
    w_rw_d       = r_rw;
    w_tx_word_d  = r_tx_word;
    w_byte_idx_d = r_byte_idx;
    w_rx_cnt_d   = r_rx_cnt;
    w_byte0_d    = r_byte0;
    w_sda_oe_d   = r_sda_oe;
    w_rd_latch_d = 1'b0;
    w_wr_data_d  = r_wr_data;
    w_wr_valid_d = 1'b0;
    w_busy_d     = r_busy;

    if (w_start) begin
      w_state_d   = StAddr;
      w_bit_cnt_d = 4'd0;
      w_rx_cnt_d  = 2'd0;
      w_sda_oe_d  = 1'b0;
      w_busy_d    = 1'b0;
    end else if (w_stop) begin
      w_state_d  = StIdle;
      w_sda_oe_d = 1'b0;
      w_busy_d   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StWaitStop: begin
          w_sda_oe_d = 1'b0;
        end
        StAddr, StRx: begin
          if (w_scl_rise) begin
            w_shift_d   = {r_shift[6:0], r_sda_sync};
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_state == StAddr) begin
              if (w_match) begin
                w_state_d  = StAddrAck;
                w_sda_oe_d = 1'b1;
                w_busy_d   = 1'b1;
                w_rw_d     = r_shift[0];
                if (r_shift[0]) begin
                  w_tx_word_d  = data_in;
                  w_rd_latch_d = 1'b1;
                end
              end else begin
                w_state_d = StWaitStop;
              end
            end else if (r_rx_cnt < 2'd2) begin
              w_state_d  = StRxAck;
              w_sda_oe_d = 1'b1;
            end else begin
              w_state_d = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (w_scl_fall) begin
            w_bit_cnt_d = 4'd0;
            if (r_rw) begin
              w_state_d    = StTx;
              w_byte_idx_d = 1'b0;
              w_sda_oe_d   = ~r_tx_word[15];
            end else begin
              w_state_d  = StRx;
              w_sda_oe_d = 1'b0;
            end
          end
        end
        StTx: begin
          if (w_scl_rise) begin
            w_bit_cnt_d = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_d  = StMack;
              w_sda_oe_d = 1'b0;
            end else begin
              w_sda_oe_d = ~w_tx_byte[3'd7 - r_bit_cnt[2:0]];
            end
          end
        end
        StMack: begin
          // byte_idx flips on the ACK so the falling edge already sees the next byte
          if (w_scl_rise) begin
            if (r_sda_sync) begin
              w_state_d  = StWaitStop;
              w_sda_oe_d = 1'b0;
            end else begin
              w_byte_idx_d = ~r_byte_idx;
            end
          end else if (w_scl_fall) begin
            w_state_d   = StTx;
            w_bit_cnt_d = 4'd0;
            w_sda_oe_d  = ~w_tx_byte[7];
          end
        end
        StRxAck: begin
          if (w_scl_fall) begin
            w_state_d   = StRx;
            w_sda_oe_d  = 1'b0;
            w_bit_cnt_d = 4'd0;
            w_rx_cnt_d  = r_rx_cnt + 2'd1;
            if (r_rx_cnt == 2'd0) begin
              w_byte0_d = r_shift;
            end else begin
              w_wr_data_d  = {r_byte0, r_shift};
              w_wr_valid_d = 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rd_latch = r_rd_latch;
  assign wr_data  = r_wr_data;
  assign wr_valid = r_wr_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_sensor_target.sv
// Bench for i2c_sensor_target: a bit-banged I2C master on a wired-AND SDA line,
// a table of read/address transactions, and hand-written write/reset sequences.
module tb_i2c_sensor_target;

  localparam int Q = 10;  // clk cycles per quarter SCL bit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        w_sda;
  logic        sda_oe;
  logic [15:0] data_in = 16'h0000;
  logic        rd_latch;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;
  int rdl_cnt = 0;
  int wrv_cnt = 0;
  int oe_cnt = 0;

  assign w_sda = sda_m & ~sda_oe;

  i2c_sensor_target #(.ADDR(7'h48)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (w_sda),
    .sda_oe   (sda_oe),
    .data_in  (data_in),
    .rd_latch (rd_latch),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (rd_latch) rdl_cnt++;
    if (wr_valid) wrv_cnt++;
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b0; wq();
    scl = 1'b0;   wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1;   wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;  wq();
    scl = 1'b1; wq(); wq();
    scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq();
    scl = 1'b1;   wq();
    b = w_sda;    wq();
    scl = 1'b0;   wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] din;
    int          nbytes;
    logic        ack;
    logic [7:0]  b0, b1, b2;
    int          rdl;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       ack;
    logic [7:0] rb, exp_b;
    int         r0, w0, o0;

    // addr, data_in, bytes read, addr ack, expected bytes, rd_latch pulses
    vecs[0] = '{8'h91, 16'h1900, 2, 1'b1, 8'h19, 8'h00, 8'h00, 1};
    vecs[1] = '{8'h92, 16'h1900, 0, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    vecs[2] = '{8'h93, 16'h1900, 0, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    vecs[3] = '{8'h91, 16'h1234, 3, 1'b1, 8'h12, 8'h34, 8'h12, 1};
    vecs[4] = '{8'h00, 16'h1234, 0, 1'b0, 8'h00, 8'h00, 8'h00, 0};
    vecs[5] = '{8'h91, 16'hA5C3, 2, 1'b1, 8'hA5, 8'hC3, 8'h00, 1};

    repeat (5) @(posedge clk);
    #1;
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_data", wr_data, 16'h0000);
    check("reset_pulses", {rd_latch, wr_valid}, 0);
    rst = 1'b0;
    wq();

    for (int v = 0; v < 6; v++) begin
      data_in = vecs[v].din;
      r0 = rdl_cnt;
      o0 = oe_cnt;
      i2c_start();
      write_byte(vecs[v].addr, ack);
      check($sformatf("row%0d_addr_ack", v), ack, vecs[v].ack);
      check($sformatf("row%0d_busy", v), busy, vecs[v].ack);
      for (int j = 0; j < vecs[v].nbytes; j++) begin
        read_byte(rb);
        if (j == 0) data_in = 16'hFFFF;
        exp_b = (j == 0) ? vecs[v].b0 : (j == 1) ? vecs[v].b1 : vecs[v].b2;
        check($sformatf("row%0d_byte%0d", v, j), rb, exp_b);
        write_bit(j == vecs[v].nbytes - 1);
      end
      wq();
      check($sformatf("row%0d_released", v), sda_oe, 0);
      if (!vecs[v].ack) check($sformatf("row%0d_oe_never", v), oe_cnt - o0, 0);
      i2c_stop();
      wq();
      check($sformatf("row%0d_busy_after_stop", v), busy, 0);
      check($sformatf("row%0d_rd_latch_cnt", v), rdl_cnt - r0, vecs[v].rdl);
    end

    // Write two bytes then a third that must be refused
    w0 = wrv_cnt;
    i2c_start();
    write_byte(8'h90, ack); check("wr_addr_ack", ack, 1);
    write_byte(8'hAB, ack); check("wr_b0_ack", ack, 1);
    write_byte(8'hCD, ack); check("wr_b1_ack", ack, 1);
    check("wr_data_abcd", wr_data, 16'hABCD);
    write_byte(8'hEE, ack); check("wr_b2_nack", ack, 0);
    i2c_stop();
    wq();
    check("wr_data_kept", wr_data, 16'hABCD);
    check("wr_valid_once", wrv_cnt - w0, 1);
    check("wr_busy_after_stop", busy, 0);

    // Partial write cut by repeated START, then read
    w0 = wrv_cnt;
    data_in = 16'h5678;
    i2c_start();
    write_byte(8'h90, ack); check("rs_addr_ack", ack, 1);
    write_byte(8'h11, ack); check("rs_b0_ack", ack, 1);
    i2c_start();
    write_byte(8'h91, ack); check("rs_read_ack", ack, 1);
    read_byte(rb); check("rs_byte0", rb, 8'h56); write_bit(1'b0);
    read_byte(rb); check("rs_byte1", rb, 8'h78); write_bit(1'b1);
    i2c_stop();
    wq();
    check("rs_no_wr_valid", wrv_cnt - w0, 0);
    check("rs_wr_data_kept", wr_data, 16'hABCD);

    // Asynchronous reset while the target drives a 0 bit
    data_in = 16'h0000;
    i2c_start();
    write_byte(8'h91, ack); check("rst_addr_ack", ack, 1);
    check("rst_tx_driving", sda_oe, 1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_release", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_data", wr_data, 16'h0000);
    check("rst_pulses", {rd_latch, wr_valid}, 0);
    wq();
    rst = 1'b0;
    wq();
    data_in = 16'hBEEF;
    r0 = rdl_cnt;
    i2c_start();
    write_byte(8'h91, ack); check("post_rst_ack", ack, 1);
    read_byte(rb); check("post_rst_byte0", rb, 8'hBE); write_bit(1'b0);
    read_byte(rb); check("post_rst_byte1", rb, 8'hEF); write_bit(1'b1);
    i2c_stop();
    wq();
    check("post_rst_rd_latch", rdl_cnt - r0, 1);
    check("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
